relu_maxpool3: RTL and testbench
================================

// Module: relu_maxpool3
// PURPOSE
//  Post-normalisation stage after batch-norm layer 3. Reads the batch-normalised feature map
//   (CHANNELS x HEIGHT x WIDTH, signed, channel-major) from the batch-norm output BRAM.
//  Applies ReLU and 2x2/stride-2 max pooling, then writes the pooled map to the next-layer BRAM.
//  Both BRAM ports are external (single-port, 1-cycle read latency).
// PARAMETERS
//  DATA_WIDTH  8    signed sample width, in and out
//  CHANNELS    128  feature channels
//  HEIGHT      7    input rows; OUT_H = HEIGHT/2 = 3 (floor, last odd row dropped)
//  WIDTH       8    input cols; OUT_W = WIDTH/2 = 4 (floor, last odd col dropped)
//  IN_ADDR_W   13   input address width; must cover CHANNELS*HEIGHT*WIDTH
//  OUT_ADDR_W  11   output address width; must cover CHANNELS*OUT_H*OUT_W
// PORTS
//  clk      in   1           single clock, all logic on posedge
//  rst      in   1           asynchronous, active-high reset
//  start    in   1           1-cycle pulse; begins a full pass (normally batch-norm done)
//  busy     out  1           high from the cycle after an accepted start until DONE
//  done     out  1           high in DONE; held until the next accepted start
//  rd_en    out  1           input BRAM enable
//  rd_addr  out  IN_ADDR_W   input BRAM address
//  rd_data  in   DATA_WIDTH  signed; valid 1 cycle after rd_en
//  wr_en    out  1           output BRAM write strobe (enable+we)
//  wr_addr  out  OUT_ADDR_W  output BRAM address
//  wr_data  out  DATA_WIDTH  pooled, ReLU'd sample (always >= 0)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; counters c/oy/ox/k = 0.
//  FSM: IDLE -> READ -> LAST -> WRITE -> READ ... -> DONE.
//   IDLE: on start -> READ, with c=oy=ox=k=0, acc=0, wr_addr=0.
//   READ (4 cycles, k=0..3): rd_en=1.
//    rd_addr = c*HEIGHT*WIDTH + (2*oy+dy)*WIDTH + (2*ox+dx).
//    (dy,dx) order per k: (0,0),(0,1),(1,0),(1,1).
//    For k>=1, capture rd_data from the previous read: acc <= max_signed(acc, rd_data).
//    k==3 -> LAST.
//   LAST: rd_en=0; acc <= max_signed(acc, rd_data) (4th sample) -> WRITE.
//   WRITE: wr_en=1, wr_data=acc, wr_addr = linear output index (c*OUT_H*OUT_W + oy*OUT_W + ox).
//    Then acc<=0 and k<=0, and the output position advances: ox++, wrap to oy++, wrap to c++.
//    Last position (c=CHANNELS-1, oy=OUT_H-1, ox=OUT_W-1) -> DONE; otherwise -> READ.
//   DONE: done=1, busy=0. A start pulse here behaves as from IDLE: done drops next cycle.
//  ReLU is folded into pooling: acc starts at 0, so the output is max(0, w0..w3).
//   Comparison is signed DATA_WIDTH; no saturation is needed.
//  Timing: exactly 6 cycles per output -> CHANNELS*OUT_H*OUT_W*6 cycles from start to the
//   last wr_en (9216 at defaults); done rises the cycle after the last wr_en.
//  Registered outputs only. rd_en and wr_en are never high in the same cycle.
//  Inputs at row HEIGHT-1 (odd HEIGHT) and col WIDTH-1 (odd WIDTH) are never read.
//  start while busy: ignored; no restart, no counter change.
//  start and rst together: rst wins.
//  rst mid-pass: all state cleared immediately, no further wr_en; the next start begins at c=0.
//  Width: index math in IN_ADDR_W/OUT_ADDR_W bits with no truncation at defaults (max in 7167, max out 1535).
// TESTING
//  1 Ramp: in[a]=a mod 128 as signed 8b, start -> out[0]=max(0,in0,in1,in8,in9)=9.
//    Exactly 1536 writes at wr_addr 0..1535, in order.
//  2 All -5 -> every wr_data==0 (ReLU); all +127 -> every wr_data==127; all -128 -> 0.
//  3 Single window: in[(0,1,0)]=+100, rest -1 (c=0, row 1, col 0) -> out[0]=100, all others 0.
//    Row 6 of any channel set to +127 -> no effect on output (dropped row).
//  4 Cycle count: start at t0 -> first rd_en at t0+1, first wr_en at t0+6.
//    done rises at t0+9217; rd_en and wr_en never both high.
//  5 Reset after 500 writes -> wr_en/busy low the same cycle.
//    Re-start -> a full clean pass from wr_addr 0 matches the golden model.
//  6 start pulses while busy (every 100 cycles) -> ignored; output identical to test 1.
//    start in DONE -> second pass identical.

Source files
------------

// File: rtl/relu_maxpool3_if.sv
// relu_maxpool3_if
//  Bundles the control handshake and both BRAM ports of relu_maxpool3.
//  slave  : the pooling engine (drives busy/done and both BRAM address/enable buses).
//  master : the surrounding system (drives start, returns input-BRAM read data).
//  Signals:
//   start   1-cycle pulse that begins a full pass
//   busy    pass in progress
//   done    pass finished, held until the next accepted start
//   rd_en   input BRAM enable
//   rd_addr input BRAM address
//   rd_data input BRAM read data, valid 1 cycle after rd_en
//   wr_en   output BRAM write strobe
//   wr_addr output BRAM address
//   wr_data pooled ReLU'd sample
interface relu_maxpool3_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_ADDR_W  = 13,
  parameter int OUT_ADDR_W = 11
);
  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         rd_en;
  logic [IN_ADDR_W-1:0]         rd_addr;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic                         wr_en;
  logic [OUT_ADDR_W-1:0]        wr_addr;
  logic signed [DATA_WIDTH-1:0] wr_data;

  modport slave (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/relu_maxpool3.sv
// relu_maxpool3
//  Reads a CHANNELS x HEIGHT x WIDTH signed feature map (channel-major) from an
//  external single-port BRAM, applies ReLU + 2x2/stride-2 max pooling and writes
//  the CHANNELS x HEIGHT/2 x WIDTH/2 result to a second external BRAM.
//  Each output takes 6 cycles: 4 READ (one BRAM read each), LAST (collect the
//  4th sample), WRITE.
//  Ports:
//   clk  posedge clock
//   rst  asynchronous active-high reset
//   bus  relu_maxpool3_if.slave: start/busy/done, rd_en/rd_addr/rd_data,
//        wr_en/wr_addr/wr_data
//  All interface outputs come straight from flops.
module relu_maxpool3 #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 128,
  parameter int HEIGHT     = 7,
  parameter int WIDTH      = 8,
  parameter int IN_ADDR_W  = 13,
  parameter int OUT_ADDR_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  relu_maxpool3_if.slave   bus
);

  localparam int OUT_H = HEIGHT / 2;
  localparam int OUT_W = WIDTH / 2;
  localparam int C_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OY_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LAST,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [C_W-1:0]               c_q, c_d;
  logic [OY_W-1:0]              oy_q, oy_d;
  logic [OX_W-1:0]              ox_q, ox_d;
  logic [1:0]                   k_q, k_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         rd_en_q, rd_en_d;
  logic [IN_ADDR_W-1:0]         rd_addr_q, rd_addr_d;
  logic                         wr_en_q, wr_en_d;
  logic [OUT_ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic signed [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                         last_pos;

  // k = {dy,dx}, so the input row is {oy,dy} (= 2*oy+dy) and the col {ox,dx}.
  function automatic logic [IN_ADDR_W-1:0] in_addr(
    input logic [C_W-1:0]  c,
    input logic [OY_W-1:0] oy,
    input logic [OX_W-1:0] ox,
    input logic [1:0]      k
  );
    return IN_ADDR_W'(c) * IN_ADDR_W'(HEIGHT * WIDTH)
         + IN_ADDR_W'({oy, k[1]}) * IN_ADDR_W'(WIDTH)
         + IN_ADDR_W'({ox, k[0]});
  endfunction

  function automatic logic [OUT_ADDR_W-1:0] out_addr(
    input logic [C_W-1:0]  c,
    input logic [OY_W-1:0] oy,
    input logic [OX_W-1:0] ox
  );
    return OUT_ADDR_W'(c) * OUT_ADDR_W'(OUT_H * OUT_W)
         + OUT_ADDR_W'(oy) * OUT_ADDR_W'(OUT_W)
         + OUT_ADDR_W'(ox);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign last_pos = (c_q  == C_W'(CHANNELS - 1)) &&
                    (oy_q == OY_W'(OUT_H - 1))   &&
                    (ox_q == OX_W'(OUT_W - 1));

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    oy_d      = oy_q;
    ox_d      = ox_q;
    k_d       = k_q;
    acc_d     = acc_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_READ;
          c_d       = '0;
          oy_d      = '0;
          ox_d      = '0;
          k_d       = '0;
          acc_d     = '0;
          wr_addr_d = '0;
        end
      end
      S_READ: begin
        // rd_data now holds the sample addressed in the previous READ cycle.
        if (k_q != 2'd0) acc_d = smax(acc_q, bus.rd_data);
        if (k_q == 2'd3) state_d = S_LAST;
        else             k_d     = k_q + 2'd1;
      end
      S_LAST: begin
        acc_d     = smax(acc_q, bus.rd_data);
        wr_data_d = acc_d;
        wr_addr_d = out_addr(c_q, oy_q, ox_q);
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        // acc restarts at 0, which is what folds ReLU into the max.
        acc_d = '0;
        k_d   = '0;
        if (last_pos) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          if (ox_q == OX_W'(OUT_W - 1)) begin
            ox_d = '0;
            if (oy_q == OY_W'(OUT_H - 1)) begin
              oy_d = '0;
              c_d  = c_q + 1'b1;
            end else begin
              oy_d = oy_q + 1'b1;
            end
          end else begin
            ox_d = ox_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered and
    // still line up with the state they belong to.
    busy_d    = (state_d == S_READ) || (state_d == S_LAST) || (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
    rd_en_d   = (state_d == S_READ);
    wr_en_d   = (state_d == S_WRITE);
    rd_addr_d = rd_en_d ? in_addr(c_d, oy_d, ox_d, k_d) : rd_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      oy_q      <= '0;
      ox_q      <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      oy_q      <= oy_d;
      ox_q      <= ox_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_relu_maxpool3.sv
// tb_relu_maxpool3
//  Directed bench for relu_maxpool3 at default parameters. A behavioural
//  1-cycle-latency BRAM feeds rd_data; a golden model fills an expected-write
//  queue before each pass and every observed wr_en pops and checks it.
module tb_relu_maxpool3;

  localparam int CH   = 128;
  localparam int H    = 7;
  localparam int W    = 8;
  localparam int OH   = H / 2;
  localparam int OW   = W / 2;
  localparam int NOUT = CH * OH * OW;

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
  } exp_t;

  logic clk;
  logic rst;

  relu_maxpool3_if #(.DATA_WIDTH(8), .IN_ADDR_W(13), .OUT_ADDR_W(11)) bus ();

  relu_maxpool3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [7:0] mem [0:8191];
  exp_t q [$];
  int   vectors;
  int   miscompares;
  int   first_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input BRAM: 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gold(input int o);
    int c, r, oy, ox, m, v, idx;
    c  = o / (OH * OW);
    r  = o % (OH * OW);
    oy = r / OW;
    ox = r % OW;
    m  = 0;
    for (int k = 0; k < 4; k++) begin
      idx = c * H * W + (2 * oy + k / 2) * W + 2 * ox + k % 2;
      v   = int'(mem[idx]);
      if (v > m) m = v;
    end
    return m;
  endfunction

  task automatic push_gold();
    exp_t e;
    q.delete();
    for (int o = 0; o < NOUT; o++) begin
      e.a = 11'(o);
      e.d = 8'(gold(o));
      q.push_back(e);
    end
  endtask

  task automatic fill_const(input int val);
    for (int a = 0; a < CH * H * W; a++) mem[a] = 8'(val);
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < CH * H * W; a++) mem[a] = 8'(a % 128);
  endtask

  task automatic fill_rand();
    for (int a = 0; a < CH * H * W; a++) mem[a] = 8'($urandom_range(0, 255));
  endtask

  // Pulses start, then watches every cycle (sampled on negedge). Relative
  // cycle i=1 is the cycle after the one in which start was high.
  // stop_after>0 returns as soon as that many writes have been seen.
  task automatic run_pass(input int stop_after, input bit pulses);
    int   i, nwr, frd, fwr, ovl, done_at;
    bit   got_done;
    exp_t e;
    nwr = 0; frd = -1; fwr = -1; ovl = 0; done_at = -1; got_done = 1'b0;
    first_data = -1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (i = 1; i <= 12000; i++) begin
      if (i == 1) chk("busy_after_start", 32'(bus.busy), 32'd1);
      if (bus.rd_en && bus.wr_en) ovl++;
      if (bus.rd_en && frd < 0) frd = i;
      if (bus.wr_en) begin
        if (fwr < 0) fwr = i;
        if (nwr == 0) first_data = int'(bus.wr_data);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
          chk("wr_data", 32'(bus.wr_data), 32'(e.d));
        end
        nwr++;
      end
      if (stop_after > 0 && nwr == stop_after) return;
      if (bus.done) begin
        got_done = 1'b1;
        done_at  = i;
        break;
      end
      bus.start = pulses && (i % 100 == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("write_count", 32'(nwr), 32'(NOUT));
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("rd_wr_overlap", 32'(ovl), 32'd0);
    chk("first_rd_cycle", 32'(frd), 32'd1);
    chk("first_wr_cycle", 32'(fwr), 32'd6);
    chk("done_cycle", 32'(done_at), 32'(NOUT * 6 + 1));
    chk("busy_in_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    first_data  = -1;
    rst         = 1'b1;
    bus.start   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_rd_en",   32'(bus.rd_en),   32'd0);
    chk("rst_wr_en",   32'(bus.wr_en),   32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp: window 0 holds 0,1,8,9.
    fill_ramp();
    push_gold();
    run_pass(0, 1'b0);
    chk("ramp_out0", 32'(first_data), 32'd9);

    // Constant maps: ReLU clamps negatives, +127 passes through.
    fill_const(-5);
    push_gold();
    run_pass(0, 1'b0);
    fill_const(127);
    push_gold();
    run_pass(0, 1'b0);
    fill_const(-128);
    push_gold();
    run_pass(0, 1'b0);

    // Single hot sample at c=0,row1,col0; dropped row 6 set to +127 everywhere.
    fill_const(-1);
    mem[1 * W + 0] = 8'sd100;
    for (int c = 0; c < CH; c++)
      for (int x = 0; x < W; x++) mem[c * H * W + 6 * W + x] = 8'sd127;
    push_gold();
    run_pass(0, 1'b0);
    chk("window_out0", 32'(first_data), 32'd100);

    // Reset after 500 writes, then a clean pass on random data.
    fill_rand();
    push_gold();
    run_pass(500, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("midrst_busy",  32'(bus.busy),  32'd0);
    chk("midrst_rd_en", 32'(bus.rd_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_gold();
    run_pass(0, 1'b0);

    // start pulses every 100 cycles while busy, then a restart from DONE.
    fill_ramp();
    push_gold();
    run_pass(0, 1'b1);
    chk("pulse_out0", 32'(first_data), 32'd9);
    push_gold();
    run_pass(0, 1'b0);
    chk("restart_out0", 32'(first_data), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
